ex_mem_skid_reg: RTL and testbench
==================================

# ex_mem_skid_reg

Parametrised EX→MEM pipeline register for the pipelined MIPS core. It carries the same execute-stage payload into the memory stage, but adds three things a plain flop stage lacks:
- a valid/ready handshake backed by a 2-entry skid buffer, so `ready_oe` comes straight from a flop;
- a flush that kills in-flight instructions on a taken branch or jump;
- a saturating stall counter for performance measurement.

## Interface
- `WIDTH`, 32: width of ALU result, store data and branch target.
- `REG_AW`, 5: destination register address width.
- `CNT_W`, 16: stall counter width.

- `clk_i`  in  1  clock; all state updates on its rising edge.
- `reset_ni`  in  1  reset, asynchronous and active-low.
- `valid_ie`  in  1  EX presents a beat.
- `ready_oe`  out  1  register can accept a beat.
- `valid_om`  out  1  MEM-side beat valid.
- `ready_im`  in  1  MEM consumes the beat.
- `flush_i`  in  1  kill all held and incoming beats.
- `zero_ie` / `zero_om`  in/out  1  ALU zero flag.
- `alu_out_ie` / `alu_out_om`  in/out  WIDTH  ALU result.
- `write_data_ie` / `write_data_om`  in/out  WIDTH  store data.
- `dst_reg_addr_ie` / `dst_reg_addr_om`  in/out  REG_AW  destination register.
- `pc_branch_ie` / `pc_branch_om`  in/out  WIDTH  branch target.
- `enable_wreg_ie` / `enable_wreg_om`  in/out  1  register write enable.
- `mem_to_reg_ie` / `mem_to_reg_om`  in/out  1  writeback select.
- `enable_wmem_ie` / `enable_wmem_om`  in/out  1  memory write enable.
- `branch_ie` / `branch_om`  in/out  1  branch instruction.
- `pc_j_ie` / `pc_j_om`  in/out  1  jump instruction.
- `stall_cnt_o`  out  CNT_W  count of cycles with `valid_om` high and `ready_im` low.

## Operation
- **Storage:** a main entry (M, drives outputs) and a skid entry (S). Each holds the full payload plus a valid bit.
- **Handshake rules:**
  - Accept = `valid_ie & ready_oe`.
  - Drain = `valid_om & ready_im`.
  - `ready_oe` = !S.valid, taken directly from a flop.
  - `valid_om` = M.valid.
- **Occupancy states** (EMPTY, ONE = M only, FULL = M+S):
  - EMPTY, accept → ONE.
  - ONE, accept without drain → FULL; the beat goes to S.
  - ONE, accept with drain → ONE; the new beat goes to M.
  - ONE, drain without accept → EMPTY.
  - FULL, drain → ONE; S moves to M, S is cleared. No accept is possible in FULL.
- **Ordering:** beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- **Control gating:** when M.valid = 0, the outputs `enable_wreg_om`, `enable_wmem_om`, `mem_to_reg_om`, `branch_om`, `pc_j_om` and `zero_om` are forced to 0. Data outputs keep their last value.
- **Flush:**
  - `flush_i` = 1 clears M.valid and S.valid at the next edge.
  - A beat accepted in the same cycle is discarded; flush has priority over accept.
  - A drain in the same cycle still completes, because the MEM stage sampled it.
- **Stall counter:**
  - Increments by 1 each cycle with `valid_om` = 1 and `ready_im` = 0.
  - Saturates at 2^CNT_W−1.
  - Is not cleared by flush.

## Timing
- **Reset (`reset_ni` = 0, asynchronous):**
  - M and S invalid; all payload flops 0.
  - `valid_om` = 0, `ready_oe` = 1, all payload outputs 0, `stall_cnt_o` = 0.
- **Reset mid-operation:** held beats are lost; the block is in EMPTY at the first edge after release.
- **Latency:** a beat accepted at edge n appears on the outputs after edge n (valid in cycle n+1), provided M was empty or draining.
- **Throughput:** 1 beat per cycle when `ready_im` is held high.
- **Stall propagation:** `ready_oe` falls one cycle after the first stalled accept (the skid absorbs that beat). It rises the cycle after the first drain from FULL.
- **Inputs:** all inputs are sampled only at the rising edge. There are no combinational paths from `ready_im` to `ready_oe`, or from `valid_ie` to `valid_om`.

## Test plan
- **Reset:** hold `reset_ni` = 0 with random inputs → all outputs 0, `ready_oe` = 1, `stall_cnt_o` = 0. Release, then send one beat with `alu_out_ie` = 0x0000_1234, `enable_wreg_ie` = 1 → next cycle `valid_om` = 1, `alu_out_om` = 0x1234, `enable_wreg_om` = 1.
- **Streaming:** `ready_im` = 1, 8 back-to-back beats with `alu_out_ie` = 1..8 → `valid_om` high for 8 consecutive cycles, values 1..8 in order, `ready_oe` never low.
- **Backpressure:** `ready_im` = 0 while beats 1,2,3 are offered → beats 1,2 held, `ready_oe` = 0 from cycle 3, beat 3 held upstream, `stall_cnt_o` counts stalled cycles. Raise `ready_im` → outputs 1,2,3 in order, no loss.
- **Flush while FULL:** in FULL with `enable_wmem` = 1 on both entries, pulse `flush_i` together with `valid_ie` → next cycle `valid_om` = 0, `enable_wmem_om` = 0, `ready_oe` = 1, incoming beat never appears.
- **Counter saturation:** CNT_W = 4, stall 20 cycles → `stall_cnt_o` = 15 and holds. Flush → still 15.
- **Async reset mid-stall:** assert `reset_ni` low asynchronously in FULL → outputs go to 0 before the next clock edge; after release, one new beat passes with 1-cycle latency.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
// EX->MEM pipeline register with a valid/ready handshake. A two-entry
// skid buffer (main entry M, skid entry S) lets ready_oe come straight
// from a flop. A flush kills held beats on a taken branch or jump. A
// saturating counter measures cycles in which MEM back-pressures a
// valid beat.
//
// Ports
//   clk_i, reset_ni           clock, asynchronous active-low reset
//   valid_ie / ready_oe       EX-side handshake
//   valid_om / ready_im       MEM-side handshake
//   flush_i                   kill held and incoming beats
//   *_ie / *_om               execute-stage payload in / out
//   stall_cnt_o               cycles with valid_om high and ready_im low
module ex_mem_skid_reg #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              valid_ie,
    output logic              ready_oe,
    output logic              valid_om,
    input  logic              ready_im,
    input  logic              flush_i,
    input  logic              zero_ie,
    output logic              zero_om,
    input  logic [WIDTH-1:0]  alu_out_ie,
    output logic [WIDTH-1:0]  alu_out_om,
    input  logic [WIDTH-1:0]  write_data_ie,
    output logic [WIDTH-1:0]  write_data_om,
    input  logic [REG_AW-1:0] dst_reg_addr_ie,
    output logic [REG_AW-1:0] dst_reg_addr_om,
    input  logic [WIDTH-1:0]  pc_branch_ie,
    output logic [WIDTH-1:0]  pc_branch_om,
    input  logic              enable_wreg_ie,
    output logic              enable_wreg_om,
    input  logic              mem_to_reg_ie,
    output logic              mem_to_reg_om,
    input  logic              enable_wmem_ie,
    output logic              enable_wmem_om,
    input  logic              branch_ie,
    output logic              branch_om,
    input  logic              pc_j_ie,
    output logic              pc_j_om,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Data fields keep their value when invalid; control fields must read 0.
    localparam int DW = 3 * WIDTH + REG_AW;
    localparam int CW = 6;

    logic [DW-1:0]    r_m_data;
    logic [CW-1:0]    r_m_ctrl;
    logic             r_m_valid;
    logic [DW-1:0]    r_s_data;
    logic [CW-1:0]    r_s_ctrl;
    logic             r_s_valid;
    logic             r_ready;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [DW-1:0]    w_in_data;
    logic [CW-1:0]    w_in_ctrl;
    logic             w_accept;
    logic             w_drain;
    logic [DW-1:0]    w_m_data_n;
    logic [CW-1:0]    w_m_ctrl_n;
    logic             w_m_valid_n;
    logic [DW-1:0]    w_s_data_n;
    logic [CW-1:0]    w_s_ctrl_n;
    logic             w_s_valid_n;
    logic [CNT_W-1:0] w_stall_cnt_n;

    assign w_in_data = {alu_out_ie, write_data_ie, dst_reg_addr_ie, pc_branch_ie};
    assign w_in_ctrl = {zero_ie, enable_wreg_ie, mem_to_reg_ie, enable_wmem_ie, branch_ie, pc_j_ie};
    assign w_accept  = valid_ie & r_ready;
    assign w_drain   = r_m_valid & ready_im;

    // Next-state of the two entries: occupancy transitions and flush.
    always_comb begin
        w_m_data_n  = r_m_data;
        w_m_ctrl_n  = r_m_ctrl;
        w_m_valid_n = r_m_valid;
        w_s_data_n  = r_s_data;
        w_s_ctrl_n  = r_s_ctrl;
        w_s_valid_n = r_s_valid;
        if (flush_i) begin
            // Any same-cycle drain already happened on the MEM side; an
            // incoming beat is simply not captured.
            w_m_valid_n = 1'b0;
            w_s_valid_n = 1'b0;
            w_m_ctrl_n  = {CW{1'b0}};
            w_s_ctrl_n  = {CW{1'b0}};
        end else begin
            case ({r_m_valid, r_s_valid})
                2'b00: begin
                    if (w_accept) begin
                        w_m_data_n  = w_in_data;
                        w_m_ctrl_n  = w_in_ctrl;
                        w_m_valid_n = 1'b1;
                    end else begin
                        w_m_valid_n = 1'b0;
                    end
                end
                2'b10: begin
                    if (w_accept && !w_drain) begin
                        w_s_data_n  = w_in_data;
                        w_s_ctrl_n  = w_in_ctrl;
                        w_s_valid_n = 1'b1;
                    end else if (w_accept && w_drain) begin
                        w_m_data_n  = w_in_data;
                        w_m_ctrl_n  = w_in_ctrl;
                    end else if (w_drain) begin
                        w_m_valid_n = 1'b0;
                        w_m_ctrl_n  = {CW{1'b0}};
                    end else begin
                        w_m_valid_n = 1'b1;
                    end
                end
                2'b11: begin
                    // ready_oe is low here, so no accept can coincide.
                    if (w_drain) begin
                        w_m_data_n  = r_s_data;
                        w_m_ctrl_n  = r_s_ctrl;
                        w_s_valid_n = 1'b0;
                        w_s_ctrl_n  = {CW{1'b0}};
                    end else begin
                        w_s_valid_n = 1'b1;
                    end
                end
                default: begin
                    // S valid without M is unreachable; recover to EMPTY.
                    w_m_valid_n = 1'b0;
                    w_s_valid_n = 1'b0;
                    w_m_ctrl_n  = {CW{1'b0}};
                    w_s_ctrl_n  = {CW{1'b0}};
                end
            endcase
        end
    end

    // Stall counter next value, saturating at all-ones.
    always_comb begin
        w_stall_cnt_n = r_stall_cnt;
        if (r_m_valid && !ready_im && (r_stall_cnt != {CNT_W{1'b1}})) begin
            w_stall_cnt_n = r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_stall_cnt_n = r_stall_cnt;
        end
    end

    // State registers; ready is registered as the inverse of next S.valid.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_m_data    <= {DW{1'b0}};
            r_m_ctrl    <= {CW{1'b0}};
            r_m_valid   <= 1'b0;
            r_s_data    <= {DW{1'b0}};
            r_s_ctrl    <= {CW{1'b0}};
            r_s_valid   <= 1'b0;
            r_ready     <= 1'b1;
            r_stall_cnt <= {CNT_W{1'b0}};
        end else begin
            r_m_data    <= w_m_data_n;
            r_m_ctrl    <= w_m_ctrl_n;
            r_m_valid   <= w_m_valid_n;
            r_s_data    <= w_s_data_n;
            r_s_ctrl    <= w_s_ctrl_n;
            r_s_valid   <= w_s_valid_n;
            r_ready     <= !w_s_valid_n;
            r_stall_cnt <= w_stall_cnt_n;
        end
    end

    assign ready_oe        = r_ready;
    assign valid_om        = r_m_valid;
    assign alu_out_om      = r_m_data[DW-1 -: WIDTH];
    assign write_data_om   = r_m_data[DW-WIDTH-1 -: WIDTH];
    assign dst_reg_addr_om = r_m_data[WIDTH+REG_AW-1 -: REG_AW];
    assign pc_branch_om    = r_m_data[WIDTH-1:0];
    assign zero_om         = r_m_ctrl[5];
    assign enable_wreg_om  = r_m_ctrl[4];
    assign mem_to_reg_om   = r_m_ctrl[3];
    assign enable_wmem_om  = r_m_ctrl[2];
    assign branch_om       = r_m_ctrl[1];
    assign pc_j_om         = r_m_ctrl[0];
    assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
module tb_ex_mem_skid_reg;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        valid_ie, ready_im, flush_i;
    logic        zero_ie, enable_wreg_ie, mem_to_reg_ie, enable_wmem_ie, branch_ie, pc_j_ie;
    logic [31:0] alu_out_ie, write_data_ie, pc_branch_ie;
    logic [4:0]  dst_reg_addr_ie;

    logic        ready_oe, valid_om;
    logic        zero_om, enable_wreg_om, mem_to_reg_om, enable_wmem_om, branch_om, pc_j_om;
    logic [31:0] alu_out_om, write_data_om, pc_branch_om;
    logic [4:0]  dst_reg_addr_om;
    logic [15:0] stall_cnt_o;

    logic        ready_oe_4, valid_om_4;
    logic        zero_om_4, enable_wreg_om_4, mem_to_reg_om_4, enable_wmem_om_4, branch_om_4, pc_j_om_4;
    logic [31:0] alu_out_om_4, write_data_om_4, pc_branch_om_4;
    logic [4:0]  dst_reg_addr_om_4;
    logic [3:0]  stall_cnt_o_4;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_mem_skid_reg u_dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .valid_ie(valid_ie), .ready_oe(ready_oe), .valid_om(valid_om), .ready_im(ready_im),
        .flush_i(flush_i),
        .zero_ie(zero_ie), .zero_om(zero_om),
        .alu_out_ie(alu_out_ie), .alu_out_om(alu_out_om),
        .write_data_ie(write_data_ie), .write_data_om(write_data_om),
        .dst_reg_addr_ie(dst_reg_addr_ie), .dst_reg_addr_om(dst_reg_addr_om),
        .pc_branch_ie(pc_branch_ie), .pc_branch_om(pc_branch_om),
        .enable_wreg_ie(enable_wreg_ie), .enable_wreg_om(enable_wreg_om),
        .mem_to_reg_ie(mem_to_reg_ie), .mem_to_reg_om(mem_to_reg_om),
        .enable_wmem_ie(enable_wmem_ie), .enable_wmem_om(enable_wmem_om),
        .branch_ie(branch_ie), .branch_om(branch_om),
        .pc_j_ie(pc_j_ie), .pc_j_om(pc_j_om),
        .stall_cnt_o(stall_cnt_o)
    );

    ex_mem_skid_reg #(.CNT_W(4)) u_dut4 (
        .clk_i(clk), .reset_ni(reset_ni),
        .valid_ie(valid_ie), .ready_oe(ready_oe_4), .valid_om(valid_om_4), .ready_im(ready_im),
        .flush_i(flush_i),
        .zero_ie(zero_ie), .zero_om(zero_om_4),
        .alu_out_ie(alu_out_ie), .alu_out_om(alu_out_om_4),
        .write_data_ie(write_data_ie), .write_data_om(write_data_om_4),
        .dst_reg_addr_ie(dst_reg_addr_ie), .dst_reg_addr_om(dst_reg_addr_om_4),
        .pc_branch_ie(pc_branch_ie), .pc_branch_om(pc_branch_om_4),
        .enable_wreg_ie(enable_wreg_ie), .enable_wreg_om(enable_wreg_om_4),
        .mem_to_reg_ie(mem_to_reg_ie), .mem_to_reg_om(mem_to_reg_om_4),
        .enable_wmem_ie(enable_wmem_ie), .enable_wmem_om(enable_wmem_om_4),
        .branch_ie(branch_ie), .branch_om(branch_om_4),
        .pc_j_ie(pc_j_ie), .pc_j_om(pc_j_om_4),
        .stall_cnt_o(stall_cnt_o_4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        valid_ie = 1'b0; ready_im = 1'b0; flush_i = 1'b0;
        zero_ie = 1'b0; enable_wreg_ie = 1'b0; mem_to_reg_ie = 1'b0;
        enable_wmem_ie = 1'b0; branch_ie = 1'b0; pc_j_ie = 1'b0;
        alu_out_ie = 32'd0; write_data_ie = 32'd0; pc_branch_ie = 32'd0;
        dst_reg_addr_ie = 5'd0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_ni = 1'b0;
        tick();
        tick();
        reset_ni = 1'b1;
    endtask

    // Present one beat; write_data/dst/pc_branch derived from alu for data checks.
    task automatic beat(input logic [31:0] alu, input logic ewreg, input logic ewmem);
        valid_ie        = 1'b1;
        alu_out_ie      = alu;
        write_data_ie   = ~alu;
        dst_reg_addr_ie = alu[4:0];
        pc_branch_ie    = alu + 32'd4;
        enable_wreg_ie  = ewreg;
        enable_wmem_ie  = ewmem;
    endtask

    task automatic test_reset;
        logic [5:0] ctrl;
        reset_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_ie = 1'($urandom); ready_im = 1'($urandom); flush_i = 1'($urandom);
            zero_ie = 1'($urandom); enable_wreg_ie = 1'($urandom); mem_to_reg_ie = 1'($urandom);
            enable_wmem_ie = 1'($urandom); branch_ie = 1'($urandom); pc_j_ie = 1'($urandom);
            alu_out_ie = $urandom; write_data_ie = $urandom; pc_branch_ie = $urandom;
            dst_reg_addr_ie = 5'($urandom);
            tick();
            ctrl = {zero_om, enable_wreg_om, mem_to_reg_om, enable_wmem_om, branch_om, pc_j_om};
            n_run++;
            if (valid_om !== 1'b0 || ready_oe !== 1'b1 || ctrl !== 6'd0 || stall_cnt_o !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_ctrl: valid=%b ready=%b ctrl=%b cnt=%0d, expected 0 1 000000 0", valid_om, ready_oe, ctrl, stall_cnt_o);
            end
            n_run++;
            if (alu_out_om !== 32'd0 || write_data_om !== 32'd0 || pc_branch_om !== 32'd0 || dst_reg_addr_om !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_data: alu=%h wd=%h pcb=%h dst=%h, expected all 0", alu_out_om, write_data_om, pc_branch_om, dst_reg_addr_om);
            end
        end
        clear_inputs();
        reset_ni = 1'b1;
        beat(32'h0000_1234, 1'b1, 1'b0);
        tick();
        n_run++;
        if (valid_om !== 1'b1 || alu_out_om !== 32'h0000_1234 || enable_wreg_om !== 1'b1) begin
            n_fail++;
            $display("FAIL first_beat: valid=%b alu=%h ewreg=%b, expected 1 00001234 1", valid_om, alu_out_om, enable_wreg_om);
        end
        clear_inputs();
        ready_im = 1'b1;
        tick();
        n_run++;
        if (valid_om !== 1'b0 || enable_wreg_om !== 1'b0 || alu_out_om !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL drain_gating: valid=%b ewreg=%b alu=%h, expected 0 0 00001234", valid_om, enable_wreg_om, alu_out_om);
        end
    endtask

    task automatic test_streaming;
        do_reset();
        ready_im = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            beat(32'(i), 1'b1, 1'b0);
            tick();
            n_run++;
            if (valid_om !== 1'b1 || ready_oe !== 1'b1 || alu_out_om !== 32'(i) ||
                write_data_om !== ~32'(i) || pc_branch_om !== 32'(i + 4) || dst_reg_addr_om !== 5'(i)) begin
                n_fail++;
                $display("FAIL stream_%0d: valid=%b ready=%b alu=%h wd=%h pcb=%h dst=%h", i, valid_om, ready_oe, alu_out_om, write_data_om, pc_branch_om, dst_reg_addr_om);
            end
        end
        valid_ie = 1'b0;
        tick();
        n_run++;
        if (valid_om !== 1'b0 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_end: valid=%b cnt=%0d, expected 0 0", valid_om, stall_cnt_o);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        ready_im = 1'b0;
        beat(32'd1, 1'b0, 1'b0);
        tick();
        n_run++;
        if (valid_om !== 1'b1 || ready_oe !== 1'b1 || alu_out_om !== 32'd1 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL bp_c1: valid=%b ready=%b alu=%h cnt=%0d, expected 1 1 1 0", valid_om, ready_oe, alu_out_om, stall_cnt_o);
        end
        beat(32'd2, 1'b0, 1'b0);
        tick();
        n_run++;
        if (valid_om !== 1'b1 || ready_oe !== 1'b0 || alu_out_om !== 32'd1 || stall_cnt_o !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_c2: valid=%b ready=%b alu=%h cnt=%0d, expected 1 0 1 1", valid_om, ready_oe, alu_out_om, stall_cnt_o);
        end
        beat(32'd3, 1'b0, 1'b0);
        tick();
        tick();
        n_run++;
        if (ready_oe !== 1'b0 || alu_out_om !== 32'd1 || stall_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_hold: ready=%b alu=%h cnt=%0d, expected 0 1 3", ready_oe, alu_out_om, stall_cnt_o);
        end
        ready_im = 1'b1;
        tick();
        n_run++;
        if (valid_om !== 1'b1 || ready_oe !== 1'b1 || alu_out_om !== 32'd2 || stall_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_out2: valid=%b ready=%b alu=%h cnt=%0d, expected 1 1 2 3", valid_om, ready_oe, alu_out_om, stall_cnt_o);
        end
        tick();
        n_run++;
        if (valid_om !== 1'b1 || alu_out_om !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_out3: valid=%b alu=%h, expected 1 3", valid_om, alu_out_om);
        end
        valid_ie = 1'b0;
        tick();
        n_run++;
        if (valid_om !== 1'b0 || ready_oe !== 1'b1 || stall_cnt_o !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_empty: valid=%b ready=%b cnt=%0d, expected 0 1 3", valid_om, ready_oe, stall_cnt_o);
        end
    endtask

    task automatic test_flush;
        do_reset();
        ready_im = 1'b0;
        beat(32'h0000_000A, 1'b0, 1'b1);
        tick();
        beat(32'h0000_000B, 1'b0, 1'b1);
        tick();
        n_run++;
        if (ready_oe !== 1'b0 || enable_wmem_om !== 1'b1 || alu_out_om !== 32'h0000_000A) begin
            n_fail++;
            $display("FAIL flush_full_pre: ready=%b ewmem=%b alu=%h, expected 0 1 0000000a", ready_oe, enable_wmem_om, alu_out_om);
        end
        beat(32'h0000_000C, 1'b0, 1'b1);
        flush_i = 1'b1;
        tick();
        n_run++;
        if (valid_om !== 1'b0 || enable_wmem_om !== 1'b0 || ready_oe !== 1'b1 ||
            alu_out_om !== 32'h0000_000A || stall_cnt_o !== 16'd2) begin
            n_fail++;
            $display("FAIL flush_full: valid=%b ewmem=%b ready=%b alu=%h cnt=%0d, expected 0 0 1 0000000a 2", valid_om, enable_wmem_om, ready_oe, alu_out_om, stall_cnt_o);
        end
        clear_inputs();
        ready_im = 1'b1;
        tick();
        tick();
        n_run++;
        if (valid_om !== 1'b0 || alu_out_om !== 32'h0000_000A) begin
            n_fail++;
            $display("FAIL flush_no_resurrect: valid=%b alu=%h, expected 0 0000000a", valid_om, alu_out_om);
        end
        beat(32'h0000_000D, 1'b1, 1'b0);
        tick();
        beat(32'h0000_000E, 1'b1, 1'b0);
        flush_i = 1'b1;
        tick();
        n_run++;
        if (valid_om !== 1'b0 || enable_wreg_om !== 1'b0 || alu_out_om !== 32'h0000_000D) begin
            n_fail++;
            $display("FAIL flush_accept: valid=%b ewreg=%b alu=%h, expected 0 0 0000000d", valid_om, enable_wreg_om, alu_out_om);
        end
        clear_inputs();
        ready_im = 1'b1;
        tick();
        n_run++;
        if (valid_om !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_discard: valid=%b, expected 0", valid_om);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        ready_im = 1'b0;
        beat(32'h0000_0077, 1'b1, 1'b0);
        tick();
        valid_ie = 1'b0;
        n_run++;
        if ({valid_om_4, ready_oe_4, enable_wreg_om_4, alu_out_om_4, dst_reg_addr_om_4} !== {1'b1, 1'b1, 1'b1, 32'h0000_0077, 5'h17} ||
            {zero_om_4, mem_to_reg_om_4, enable_wmem_om_4, branch_om_4, pc_j_om_4} !== 5'd0 ||
            write_data_om_4 !== 32'hFFFF_FF88 || pc_branch_om_4 !== 32'h0000_007B) begin
            n_fail++;
            $display("FAIL sat_beat: valid=%b ready=%b ewreg=%b alu=%h wd=%h pcb=%h", valid_om_4, ready_oe_4, enable_wreg_om_4, alu_out_om_4, write_data_om_4, pc_branch_om_4);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                n_run++;
                if (stall_cnt_o_4 !== 4'd14) begin
                    n_fail++;
                    $display("FAIL sat_14: cnt4=%0d, expected 14", stall_cnt_o_4);
                end
            end
            if (i == 15 || i == 20) begin
                n_run++;
                if (stall_cnt_o_4 !== 4'd15 || stall_cnt_o !== 16'(i)) begin
                    n_fail++;
                    $display("FAIL sat_%0d: cnt4=%0d cnt16=%0d, expected 15 %0d", i, stall_cnt_o_4, stall_cnt_o, i);
                end
            end
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_run++;
        if (stall_cnt_o_4 !== 4'd15 || stall_cnt_o !== 16'd21 || valid_om !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flush: cnt4=%0d cnt16=%0d valid=%b, expected 15 21 0", stall_cnt_o_4, stall_cnt_o, valid_om);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        ready_im = 1'b0;
        beat(32'h0000_0011, 1'b0, 1'b1);
        tick();
        beat(32'h0000_0022, 1'b0, 1'b1);
        tick();
        n_run++;
        if (ready_oe !== 1'b0 || valid_om !== 1'b1 || stall_cnt_o !== 16'd1) begin
            n_fail++;
            $display("FAIL ar_full: ready=%b valid=%b cnt=%0d, expected 0 1 1", ready_oe, valid_om, stall_cnt_o);
        end
        clear_inputs();
        #2;
        reset_ni = 1'b0;
        #1;
        n_run++;
        if (valid_om !== 1'b0 || ready_oe !== 1'b1 || alu_out_om !== 32'd0 ||
            enable_wmem_om !== 1'b0 || stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL ar_async: valid=%b ready=%b alu=%h ewmem=%b cnt=%0d, expected 0 1 0 0 0", valid_om, ready_oe, alu_out_om, enable_wmem_om, stall_cnt_o);
        end
        tick();
        reset_ni = 1'b1;
        ready_im = 1'b1;
        beat(32'h0000_0055, 1'b1, 1'b0);
        tick();
        n_run++;
        if (valid_om !== 1'b1 || alu_out_om !== 32'h0000_0055 || enable_wreg_om !== 1'b1 || ready_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_after: valid=%b alu=%h ewreg=%b ready=%b, expected 1 00000055 1 1", valid_om, alu_out_om, enable_wreg_om, ready_oe);
        end
        valid_ie = 1'b0;
        tick();
        n_run++;
        if (valid_om !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_drain: valid=%b, expected 0", valid_om);
        end
    endtask

    initial begin
        reset_ni = 1'b0;
        clear_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
